// File: rtl/nibble_pack_fifo_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nibble_pack_fifo_if : nibble-in / byte-out handshake bundle for nibble_pack_fifo
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
interface nibble_pack_fifo_if #(
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic          in_valid;
  logic [3:0]    in_nib;
  logic          in_ready;
  logic          flush;
  logic          out_valid;
  logic [7:0]    out_byte;
  logic          out_partial;
  logic          out_ready;
  logic [AW:0]   count;
  logic          err;

  // Block side: consumes nibbles, produces bytes.
  modport slave (
    input  in_valid, in_nib, flush, out_ready,
    output in_ready, out_valid, out_byte, out_partial, count, err
  );

  // Environment side: upstream producer plus byte sink.
  modport master (
    output in_valid, in_nib, flush, out_ready,
    input  in_ready, out_valid, out_byte, out_partial, count, err
  );
endinterface
`default_nettype wire

// File: rtl/nibble_pack_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nibble_pack_fifo : packs 4-bit nibbles into bytes, buffers them in a show-ahead FIFO
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
module nibble_pack_fifo #(
  parameter int  DEPTH     = 4,
  parameter bit  LSN_FIRST = 1'b1,
  localparam int AW        = $clog2(DEPTH)
) (
  input  wire logic         clk,
  input  wire logic         rst,
  nibble_pack_fifo_if.slave bus
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_HALF  = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   hold_q, hold_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]  count_q, count_d;
  logic         err_q, err_d;
  logic [8:0]   mem_q [DEPTH];
  logic [8:0]   mem_d [DEPTH];

  logic         full;
  logic         in_ready;
  logic         accept;
  logic         pop;
  logic         push;
  logic [8:0]   push_entry;
  logic [8:0]   head;
  logic [7:0]   full_byte;
  logic [7:0]   pad_byte;

  // Nibble ordering inside the byte is fixed at elaboration time.
  generate
    if (LSN_FIRST) begin : g_lsn_first
      assign full_byte = {bus.in_nib, hold_q};
      assign pad_byte  = {4'h0, hold_q};
    end else begin : g_msn_first
      assign full_byte = {hold_q, bus.in_nib};
      assign pad_byte  = {hold_q, 4'h0};
    end
  endgenerate

  assign full     = (count_q == FULL_CNT);
  // Registered-only: a pop this cycle does not open the input.
  assign in_ready = !((state_q == S_HALF) && full);
  assign accept   = bus.in_valid && in_ready;
  assign pop      = (count_q != '0) && bus.out_ready;
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    push       = 1'b0;
    push_entry = 9'h000;

    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          hold_d  = bus.in_nib;
          state_d = S_HALF;
        end
      end
      S_HALF: begin
        if (accept) begin
          push       = 1'b1;
          push_entry = {1'b0, full_byte};
          state_d    = S_EMPTY;
        end else if (bus.flush && !bus.in_valid && !full) begin
          push       = 1'b1;
          push_entry = {1'b1, pad_byte};
          state_d    = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Offending nibble is simply not accepted; only the flag records it.
  always_comb begin
    err_d = err_q || (bus.in_valid && !in_ready);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_EMPTY;
      hold_q   <= 4'h0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 9'h000;
      end
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = (count_q != '0);
  assign bus.out_byte    = (count_q != '0) ? head[7:0] : 8'h00;
  assign bus.out_partial = (count_q != '0) ? head[8]   : 1'b0;
  assign bus.count       = count_q;
  assign bus.err         = err_q;

  a_count_bound : assert property (@(posedge clk) disable iff (!rst) count_q <= FULL_CNT);
  a_no_full_push : assert property (@(posedge clk) disable iff (!rst) !(push && full));

endmodule
`default_nettype wire

// File: tb/tb_nibble_pack_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_nibble_pack_fifo : directed bench for nibble_pack_fifo, both nibble orders
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_nibble_pack_fifo;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  nibble_pack_fifo_if #(.DEPTH(4)) bus_lsn ();
  nibble_pack_fifo_if #(.DEPTH(4)) bus_msn ();

  nibble_pack_fifo #(.DEPTH(4), .LSN_FIRST(1'b1)) u_dut_lsn (
    .clk (clk),
    .rst (rst),
    .bus (bus_lsn.slave)
  );

  nibble_pack_fifo #(.DEPTH(4), .LSN_FIRST(1'b0)) u_dut_msn (
    .clk (clk),
    .rst (rst),
    .bus (bus_msn.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_lsn(input logic [3:0] n);
    bus_lsn.in_valid = 1'b1;
    bus_lsn.in_nib   = n;
    step();
    bus_lsn.in_valid = 1'b0;
  endtask

  task automatic send_msn(input logic [3:0] n);
    bus_msn.in_valid = 1'b1;
    bus_msn.in_nib   = n;
    step();
    bus_msn.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  logic [7:0] drain_exp [4] = '{8'h21, 8'h43, 8'h65, 8'h87};

  initial begin
    bus_lsn.in_valid = 1'b0; bus_lsn.in_nib = 4'h0; bus_lsn.flush = 1'b0; bus_lsn.out_ready = 1'b0;
    bus_msn.in_valid = 1'b0; bus_msn.in_nib = 4'h0; bus_msn.flush = 1'b0; bus_msn.out_ready = 1'b0;

    // Reset state
    step();
    check("rst_out_valid",   32'(bus_lsn.out_valid),   32'd0);
    check("rst_out_partial", 32'(bus_lsn.out_partial), 32'd0);
    check("rst_out_byte",    32'(bus_lsn.out_byte),    32'h00);
    check("rst_in_ready",    32'(bus_lsn.in_ready),    32'd1);
    check("rst_count",       32'(bus_lsn.count),       32'd0);
    check("rst_err",         32'(bus_lsn.err),         32'd0);
    step();
    rst = 1'b1;

    // 1: basic pair, sink always ready
    bus_lsn.out_ready = 1'b1;
    send_lsn(4'h3);
    check("t1_half_count", 32'(bus_lsn.count), 32'd0);
    send_lsn(4'hA);
    check("t1_out_valid",   32'(bus_lsn.out_valid),   32'd1);
    check("t1_out_byte",    32'(bus_lsn.out_byte),    32'hA3);
    check("t1_out_partial", 32'(bus_lsn.out_partial), 32'd0);
    step();
    check("t1_count_after_pop", 32'(bus_lsn.count),     32'd0);
    check("t1_valid_after_pop", 32'(bus_lsn.out_valid), 32'd0);

    // 2: fill to DEPTH, overflow nibble, drain in order
    bus_lsn.out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      send_lsn(4'(i));
      check("t2_fill_in_ready", 32'(bus_lsn.in_ready), 32'd1);
    end
    check("t2_full_count", 32'(bus_lsn.count), 32'd4);
    send_lsn(4'h9);
    check("t2_half_full_in_ready", 32'(bus_lsn.in_ready), 32'd0);
    check("t2_err_before", 32'(bus_lsn.err), 32'd0);
    send_lsn(4'hA);
    check("t2_err_set",     32'(bus_lsn.err),   32'd1);
    check("t2_count_held",  32'(bus_lsn.count), 32'd4);
    bus_lsn.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_valid", 32'(bus_lsn.out_valid), 32'd1);
      check("t2_drain_byte",  32'(bus_lsn.out_byte),  32'(drain_exp[i]));
      step();
    end
    check("t2_drained_count", 32'(bus_lsn.count), 32'd0);
    check("t2_err_sticky",    32'(bus_lsn.err),   32'd1);
    bus_lsn.out_ready = 1'b0;
    do_reset();
    check("t2_err_cleared", 32'(bus_lsn.err), 32'd0);

    // 3: flush pads a half byte; flush in EMPTY does nothing
    send_lsn(4'h5);
    bus_lsn.flush = 1'b1;
    step();
    bus_lsn.flush = 1'b0;
    check("t3_flush_count",   32'(bus_lsn.count),       32'd1);
    check("t3_flush_byte",    32'(bus_lsn.out_byte),    32'h05);
    check("t3_flush_partial", 32'(bus_lsn.out_partial), 32'd1);
    bus_lsn.flush = 1'b1;
    step();
    bus_lsn.flush = 1'b0;
    check("t3_empty_flush_count", 32'(bus_lsn.count), 32'd1);
    bus_lsn.out_ready = 1'b1;
    step();
    bus_lsn.out_ready = 1'b0;
    check("t3_pop_count", 32'(bus_lsn.count), 32'd0);

    // 4: nibble beats flush in the same cycle
    send_lsn(4'hC);
    bus_lsn.in_valid = 1'b1;
    bus_lsn.in_nib   = 4'hD;
    bus_lsn.flush    = 1'b1;
    step();
    bus_lsn.in_valid = 1'b0;
    bus_lsn.flush    = 1'b0;
    check("t4_count",   32'(bus_lsn.count),       32'd1);
    check("t4_byte",    32'(bus_lsn.out_byte),    32'hDC);
    check("t4_partial", 32'(bus_lsn.out_partial), 32'd0);
    step();
    check("t4_no_pad_byte", 32'(bus_lsn.count), 32'd1);
    bus_lsn.out_ready = 1'b1;
    step();
    bus_lsn.out_ready = 1'b0;
    check("t4_pop_count", 32'(bus_lsn.count), 32'd0);

    // 5: MSN-first ordering
    send_msn(4'h3);
    send_msn(4'hA);
    check("t5_valid", 32'(bus_msn.out_valid), 32'd1);
    check("t5_byte",  32'(bus_msn.out_byte),  32'h3A);
    check("t5_count", 32'(bus_msn.count),     32'd1);

    // 6: continuous stream against a popping sink, then async reset
    for (int i = 1; i <= 4; i++) begin
      send_lsn(4'(i));
    end
    check("t6_start_count", 32'(bus_lsn.count), 32'd2);
    bus_lsn.out_ready = 1'b1;
    bus_lsn.in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus_lsn.in_nib = 4'(i + 5);
      step();
      check("t6_count_le2", 32'(bus_lsn.count <= 3'd2), 32'd1);
      check("t6_in_ready",  32'(bus_lsn.in_ready),      32'd1);
      check("t6_no_err",    32'(bus_lsn.err),           32'd0);
    end
    check("t6_mid_count", 32'(bus_lsn.count),     32'd1);
    check("t6_mid_valid", 32'(bus_lsn.out_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_valid",    32'(bus_lsn.out_valid), 32'd0);
    check("t6_async_count",    32'(bus_lsn.count),     32'd0);
    check("t6_async_in_ready", 32'(bus_lsn.in_ready),  32'd1);
    check("t6_msn_async_count", 32'(bus_msn.count),    32'd0);
    bus_lsn.in_valid  = 1'b0;
    bus_lsn.out_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("t6_post_reset_count", 32'(bus_lsn.count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
